seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode 7-seg display.
//  - Shares one BCD-to-7-seg decoder across all digits: drives its bcd input plus one anode per digit.
//  - Inserts a blanking gap between digits against ghosting.
//  - Host updates are double-buffered; they commit only at frame boundaries, so no partial frame is ever shown.
// PARAMETERS
//  NUM_DIGITS    4     digits scanned, legal 1..8
//  PRESCALE      50000 clk cycles each digit is driven (DRIVE dwell), >=1
//  BLANK_CYCLES  2     clk cycles of all-anodes-off gap after each digit, >=0 (0 = no GAP state)
//  AN_ACTIVE_LOW 1     1: anode asserted = 0; 0: anode asserted = 1
// PORTS
//  clk          in   1              system clock, rising edge
//  rst_n        in   1              asynchronous active-low reset
//  en           in   1              scan enable; 0 = display dark
//  load         in   1              1-cycle strobe: capture digits_in/dp_in into shadow
//  digits_in    in   4*NUM_DIGITS   BCD digits; [3:0] = digit 0 (least significant)
//  dp_in        in   NUM_DIGITS     decimal point per digit
//  pending      out  1              shadow holds data not yet committed
//  bcd_out      out  4              to decoder bcd input; 4'hF = blank
//  dp_out       out  1              decimal point for current digit (active high)
//  anode        out  NUM_DIGITS     digit select; polarity per AN_ACTIVE_LOW
//  frame_start  out  1              1-cycle pulse when digit 0 becomes driven
// BEHAVIOUR
//  Reset values: anode all deasserted, bcd_out=4'hF, dp_out=0, frame_start=0, pending=0.
//  Active and shadow registers reset to 0. State resets to OFF.
//  Outputs are registered and change on the same edge as the state.
//  FSM states:
//  - OFF: en=1 -> DRIVE digit 0 on the next edge; frame boundary.
//  - DRIVE: selected anode asserted; bcd_out/dp_out from the active register.
//    Holds PRESCALE cycles, then GAP, or next DRIVE if BLANK_CYCLES=0.
//  - GAP: anodes deasserted, bcd_out=4'hF, dp_out=0. Holds BLANK_CYCLES cycles, then DRIVE of idx+1.
//  Digit index wraps NUM_DIGITS-1 -> 0. Entry into DRIVE of digit 0 is a frame boundary:
//  - if pending=1, commit shadow to active (the new value is visible in that same DRIVE cycle) and clear pending;
//  - pulse frame_start.
//  en=0 in any state: next edge -> OFF, outputs at reset values, dwell counter and index cleared; shadow/pending kept.
//  load: captures into shadow and sets pending on the next edge. A load while pending overwrites the shadow (last wins).
//  load on the same edge as a commit: the old shadow commits; the new data lands in shadow with pending=1.
//  BCD codes 10..15 pass through unchanged; the decoder blanks them.
//  Frame period = NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
//  Counter widths: dwell = $clog2(max(PRESCALE,BLANK_CYCLES)+1); index = max(1,$clog2(NUM_DIGITS)).
//  Reset asserted mid-scan: immediate, asynchronous return to reset values.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//  - In DRIVE, digit i>0 shows bcd_out=4'hF when it and all more-significant active digits are 0 and no dp is set at or above i.
//  - Anode timing is unchanged. Digit 0 is never suppressed.
//  Undefined: every digit is shown as stored; no suppression logic is built.
// STRUCTURE
//  Package seg7_pkg:
//  - BLANK_CODE=4'hF.
//  - State encoding typedef {OFF, DRIVE, GAP}.
//  - Anode-assert helper function honouring AN_ACTIVE_LOW.
//  Sub-module seg7_scan_timer: dwell counter with load/terminal-count. One instance.
//  Leading-zero mask is an inline generate block under the macro.
// TESTING (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, AN_ACTIVE_LOW=1)
//  1. Reset, then en=1 with digits 0x1234 loaded before en -> first edge: anode=4'b1110, bcd_out=4, frame_start=1.
//     Anode holds 4 cycles, then 1 cycle anode=4'b1111 with bcd_out=F. Sequence is 4,3,2,1; frame_start period = 20 cycles.
//  2. load 0x5678 mid-frame -> pending=1 and digits 4..1 still shown.
//     At the next frame_start, bcd_out=8 and pending=0.
//  3. Two loads (0x1111, then 0x2222) in one frame -> only 2s are displayed; pending clears once.
//  4. en=0 during DRIVE of digit 2 -> next edge anode=4'b1111, bcd_out=F.
//     en=1 again -> resumes at digit 0 with frame_start=1.
//  5. LEADING_ZERO_BLANK_EN with 0x0070 -> digit3,digit2 bcd_out=F, digit1=7, digit0=0.
//     Same digits with dp_in=4'b0100 -> digit2 shows 0, dp_out=1 only on digit 2.
//  6. rst_n low mid-DRIVE -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, scan state encoding and anode polarity helper
//   BLANK_CODE  bcd value the decoder renders as all segments off
//   scan_state_t OFF / DRIVE / GAP
//   an_level()  physical anode level for a logical select, honouring polarity
package seg7_pkg;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    typedef enum logic [1:0] {OFF, DRIVE, GAP} scan_state_t;
    function automatic logic an_level(input logic on, input logic active_low);
        return active_low ? ~on : on;
    endfunction
endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: dwell down-counter with synchronous clear, load and terminal count
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         force count to zero (scan disabled)
//   load        load load_val (entering a new dwell)
//   load_val    dwell length minus one
//   tc          count is zero: the current dwell ends on this edge
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign tc = cnt == '0;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for an N-digit 7-seg display
//   clk, rst_n   clock, asynchronous active-low reset
//   en           scan enable, 0 = display dark
//   load         strobe capturing digits_in/dp_in into the shadow register
//   digits_in    BCD digits, [3:0] = digit 0; dp_in decimal points
//   pending      shadow holds data not yet committed to the display
//   bcd_out      shared decoder input (BLANK_CODE = off); dp_out decimal point
//   anode        digit select, polarity set by AN_ACTIVE_LOW
//   frame_start  one-cycle pulse when digit 0 becomes driven
//   Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE      = 50000,
    parameter int BLANK_CYCLES  = 2,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    pending,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);
    localparam int DW = $clog2((PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES) + 1);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0] DRIVE_LD = DW'(PRESCALE - 1);
    localparam logic [DW-1:0] GAP_LD = DW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] IDX0 = '0;
    localparam logic AN_LOW = AN_ACTIVE_LOW != 0;

    scan_state_t state, nxt_state;
    logic [IW-1:0] idx, nxt_idx;
    logic [4*NUM_DIGITS-1:0] act_dig, shd_dig, nxt_act_dig;
    logic [NUM_DIGITS-1:0] act_dp, shd_dp, nxt_act_dp, lz_mask, nxt_anode;
    logic [3:0] nxt_bcd;
    logic tc, enter_drive, frame, commit, t_load, nxt_dp;

    seg7_scan_timer #(.W(DW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!en),
        .load     (t_load),
        .load_val (nxt_state == GAP ? GAP_LD : DRIVE_LD),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= OFF;
            idx         <= '0;
            act_dig     <= '0;
            act_dp      <= '0;
            shd_dig     <= '0;
            shd_dp      <= '0;
            pending     <= 1'b0;
            bcd_out     <= BLANK_CODE;
            dp_out      <= 1'b0;
            anode       <= {NUM_DIGITS{an_level(1'b0, AN_LOW)}};
            frame_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            act_dig     <= nxt_act_dig;
            act_dp      <= nxt_act_dp;
            if (load) begin
                shd_dig <= digits_in;
                shd_dp  <= dp_in;
            end
            // a load coinciding with a commit re-arms pending for the new data
            pending     <= load || (pending && !commit);
            bcd_out     <= nxt_bcd;
            dp_out      <= nxt_dp;
            anode       <= nxt_anode;
            frame_start <= frame;
        end

    always_comb begin
        nxt_state = !en ? OFF :
                    state == OFF ? DRIVE :
                    !tc ? state :
                    state == DRIVE && BLANK_CYCLES > 0 ? GAP : DRIVE;
        enter_drive = nxt_state == DRIVE && (state != DRIVE || tc);
        nxt_idx = !en || state == OFF ? IDX0 :
                  !enter_drive ? idx :
                  idx == LAST_IDX ? IDX0 : idx + 1'b1;
        frame = enter_drive && nxt_idx == IDX0;
        commit = frame && pending;
        t_load = nxt_state != OFF && (state == OFF || tc);
        // committed data must already be visible in the first DRIVE cycle of the frame
        nxt_act_dig = commit ? shd_dig : act_dig;
        nxt_act_dp = commit ? shd_dp : act_dp;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // digit g>0 is blank when it and every more-significant digit is 0 with no dp set
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
        assign lz_mask[g] = g != 0 && nxt_act_dig[4*NUM_DIGITS-1:4*g] == '0 &&
                            nxt_act_dp[NUM_DIGITS-1:g] == '0;
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        nxt_bcd = nxt_state == DRIVE && !lz_mask[nxt_idx] ? nxt_act_dig[4*nxt_idx +: 4] : BLANK_CODE;
        nxt_dp = nxt_state == DRIVE && nxt_act_dp[nxt_idx];
        for (int i = 0; i < NUM_DIGITS; i++)
            nxt_anode[i] = an_level(nxt_state == DRIVE && nxt_idx == IW'(i), AN_LOW);
    end
endmodule
